// File: rtl/fifo_axis_drain_pkg.sv
// Shared types for the FIFO-to-AXI-Stream drain: buffer state encoding and
// the index-width helper used to size beat_idx.
package fifo_axis_drain_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

   // Width needed to count 0..n-1, never less than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_axis_drain_if.sv
// AXI-Stream handshake bundle produced by the drain.
interface fifo_axis_drain_if #(
   parameter int unsigned DW = 32
);
   logic          tvalid;
   logic          tready;
   logic [DW-1:0] tdata;
   logic          tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fifo_axis_drain_skid.sv
// Two-entry head/skid buffer: registered outputs with full throughput.
module fifo_axis_drain_skid
   import fifo_axis_drain_pkg::*;
#(
   parameter int unsigned W = 33
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         ready,
   output logic         valid,
   output logic         full,
   output logic [W-1:0] head,
   output logic [1:0]   occupancy
);

   buf_state_t   state;
   logic [W-1:0] skid;
   logic         out;

   assign valid     = (state != EMPTY);
   assign full      = (state == TWO);
   assign occupancy = state;
   assign out       = valid & ready;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  head  <= push_data;
                  state <= ONE;
               end
            end
            ONE: begin
               if (push && !out) begin
                  skid  <= push_data;
                  state <= TWO;
               end else if (push && out) begin
                  head  <= push_data;
               end else if (out) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               // No push can arrive here: the pop strobe is gated by full.
               if (out) begin
                  head  <= skid;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/fifo_axis_drain.sv
// Drains a first-word-fall-through FIFO into an AXI-Stream master, framing
// fixed-length bursts with tlast and counting completed packets.
module fifo_axis_drain
   import fifo_axis_drain_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                                clk,
   input  logic                                rst_,
   input  logic                                en,
   input  logic                                fifo_empty,
   input  logic [DW-1:0]                       fifo_data,
   output logic                                fifo_rd_en,
   fifo_axis_drain_if.master                   m,
   output logic [1:0]                          occupancy,
   output logic [idx_width(BURST_LEN)-1:0]     beat_idx,
   output logic [CNT_W-1:0]                    pkt_cnt
);

   localparam int unsigned     BW       = idx_width(BURST_LEN);
   localparam logic [BW-1:0]   LAST_IDX = BW'(BURST_LEN - 1);

   logic          full;
   logic          valid;
   logic          tlast_calc;
   logic          handshake;
   logic [DW:0]   head;

   // Held off while rst_ is low so nothing is popped into a buffer being cleared.
   assign fifo_rd_en = rst_ & en & ~fifo_empty & ~full;
   assign tlast_calc = (beat_idx == LAST_IDX);

   fifo_axis_drain_skid #(.W(DW + 1)) u_skid (
      .clk       (clk),
      .rst_      (rst_),
      .push      (fifo_rd_en),
      .push_data ({fifo_data, tlast_calc}),
      .ready     (m.tready),
      .valid     (valid),
      .full      (full),
      .head      (head),
      .occupancy (occupancy)
   );

   assign m.tvalid = valid;
   assign m.tdata  = head[DW:1];
   assign m.tlast  = head[0];
   assign handshake = valid & m.tready;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         beat_idx <= '0;
         pkt_cnt  <= '0;
      end else begin
         if (fifo_rd_en)
            beat_idx <= tlast_calc ? '0 : beat_idx + BW'(1);
         if (handshake && m.tlast)
            pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Bench for fifo_axis_drain: three configurations fed from queue-based FIFO
// models, with a beat-numbering scoreboard for data, tlast and packet counts.
module tb_fifo_axis_drain;
   import fifo_axis_drain_pkg::*;

   localparam int BLS [3] = '{16, 7, 1};
   localparam int CWS [3] = '{16, 16, 4};

   logic clk = 1'b0;
   logic rst_;
   always #5 clk = ~clk;

   logic        en [3];
   logic        empty [3];
   logic        rd_en [3];
   logic        tvalid [3];
   logic        tready [3];
   logic        tlast [3];
   logic [31:0] fdata [3];
   logic [31:0] tdata [3];
   logic [1:0]  occ [3];
   logic [15:0] bidx [3];
   logic [15:0] pkt [3];

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int unsigned BW = idx_width(BLS[g]);
      localparam int unsigned CW = CWS[g];
      fifo_axis_drain_if #(.DW(32)) s ();
      logic [BW-1:0] b;
      logic [CW-1:0] p;
      logic          re;
      logic [1:0]    o;

      fifo_axis_drain #(.DW(32), .BURST_LEN(BLS[g]), .CNT_W(CW)) dut (
         .clk        (clk),
         .rst_       (rst_),
         .en         (en[g]),
         .fifo_empty (empty[g]),
         .fifo_data  (fdata[g]),
         .fifo_rd_en (re),
         .m          (s),
         .occupancy  (o),
         .beat_idx   (b),
         .pkt_cnt    (p)
      );

      assign s.tready = tready[g];
      assign tvalid[g] = s.tvalid;
      assign tdata[g]  = s.tdata;
      assign tlast[g]  = s.tlast;
      assign rd_en[g]  = re;
      assign occ[g]    = o;
      assign bidx[g]   = 16'(b);
      assign pkt[g]    = 16'(p);
   end

   logic [31:0] fq [3][$];
   logic [31:0] sb [3][$];
   int unsigned nb [3];
   int unsigned np [3];
   int          total = 0;
   int          bad = 0;
   bit          rnd = 1'b0;
   int          fill_left = 0;
   logic [31:0] next_word = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int g);
      empty[g] = (fq[g].size() == 0);
      fdata[g] = (fq[g].size() > 0) ? fq[g][0] : '0;
   endtask

   task automatic load(input int g, input logic [31:0] w);
      fq[g].push_back(w);
      sb[g].push_back(w);
      drive(g);
   endtask

   function automatic logic [31:0] pkt_exp(input int g);
      return 32'(np[g] % (32'd1 << CWS[g]));
   endfunction

   // Observe the cycle just before a rising edge, then advance one clock.
   task automatic tick();
      logic [31:0] w;
      logic        last_exp;
      #1;
      for (int g = 0; g < 3; g++) begin
         if (rd_en[g]) begin
            chk("pop_nonempty", {31'd0, empty[g]}, 32'd0);
            if (fq[g].size() > 0) void'(fq[g].pop_front());
         end
         if (tvalid[g] && tready[g]) begin
            if (sb[g].size() == 0) begin
               chk("spurious_beat", {31'd0, tvalid[g]}, 32'd0);
            end else begin
               w = sb[g].pop_front();
               last_exp = ((nb[g] % BLS[g]) == BLS[g] - 1);
               chk("tdata", tdata[g], w);
               chk("tlast", {31'd0, tlast[g]}, {31'd0, last_exp});
               if (last_exp) np[g]++;
               nb[g]++;
            end
         end
      end
      @(posedge clk);
      #1;
      if (rnd) begin
         tready[1] = 1'($urandom_range(0, 1));
         if (fill_left > 0 && $urandom_range(0, 1) == 1) begin
            load(1, next_word);
            next_word++;
            fill_left--;
         end
      end
      for (int g = 0; g < 3; g++) drive(g);
      @(negedge clk);
   endtask

   task automatic drain(input int g, input int budget);
      int n = 0;
      while (sb[g].size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_left", 32'(sb[g].size()), 32'd0);
   endtask

   initial begin
      int unsigned start;
      int          n;

      rst_ = 1'b0;
      for (int g = 0; g < 3; g++) begin
         en[g] = 1'b1;
         tready[g] = 1'b0;
         nb[g] = 0;
         np[g] = 0;
         drive(g);
      end
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      #1;
      chk("rst_tvalid", {31'd0, tvalid[0]}, 32'd0);
      chk("rst_occ", {30'd0, occ[0]}, 32'd0);
      chk("rst_bidx", {16'd0, bidx[0]}, 32'd0);
      chk("rst_pkt", {16'd0, pkt[0]}, 32'd0);
      chk("rst_rd_en", {31'd0, rd_en[0]}, 32'd0);
      chk("rst_tdata", tdata[0], 32'd0);
      chk("rst_tlast", {31'd0, tlast[0]}, 32'd0);

      // Back-to-back drain of 32 words, one-cycle pop-to-valid latency.
      tready[0] = 1'b1;
      for (int i = 0; i < 32; i++) load(0, 32'(i));
      #1;
      chk("lat_rd_en", {31'd0, rd_en[0]}, 32'd1);
      chk("lat_tvalid_pre", {31'd0, tvalid[0]}, 32'd0);
      tick();
      chk("lat_tvalid_post", {31'd0, tvalid[0]}, 32'd1);
      chk("lat_tdata", tdata[0], 32'd0);
      start = nb[0];
      repeat (32) tick();
      chk("b2b_beats", 32'(nb[0] - start), 32'd32);
      chk("b2b_pkt", {16'd0, pkt[0]}, 32'd2);
      chk("b2b_idle", {31'd0, tvalid[0]}, 32'd0);

      // Backpressure: fill to two entries, hold, then release.
      tready[0] = 1'b0;
      for (int i = 0; i < 5; i++) load(0, 32'(100 + i));
      repeat (4) tick();
      chk("bp_occ", {30'd0, occ[0]}, 32'd2);
      chk("bp_rd_en", {31'd0, rd_en[0]}, 32'd0);
      chk("bp_tvalid", {31'd0, tvalid[0]}, 32'd1);
      chk("bp_tdata", tdata[0], 32'd100);
      tick();
      chk("bp_tdata_hold", tdata[0], 32'd100);
      chk("bp_occ_hold", {30'd0, occ[0]}, 32'd2);
      tready[0] = 1'b1;
      start = nb[0];
      repeat (5) tick();
      chk("bp_beats", 32'(nb[0] - start), 32'd5);
      chk("bp_idle", {31'd0, tvalid[0]}, 32'd0);
      chk("bp_bidx", {16'd0, bidx[0]}, 32'(nb[0] % BLS[0]));

      // en dropped mid-packet: framing resumes from the same beat.
      for (int i = 0; i < 20; i++) load(0, 32'(200 + i));
      n = 0;
      while (bidx[0] != 16'd6 && n < 10) begin
         tick();
         n++;
      end
      chk("en_reach_idx6", {16'd0, bidx[0]}, 32'd6);
      en[0] = 1'b0;
      repeat (10) begin
         #1;
         chk("en_low_rd_en", {31'd0, rd_en[0]}, 32'd0);
         tick();
      end
      chk("en_low_bidx", {16'd0, bidx[0]}, 32'd6);
      chk("en_low_tvalid", {31'd0, tvalid[0]}, 32'd0);
      chk("en_low_occ", {30'd0, occ[0]}, 32'd0);
      en[0] = 1'b1;
      #1;
      chk("en_resume_rd_en", {31'd0, rd_en[0]}, 32'd1);
      drain(0, 100);
      chk("en_pkt", {16'd0, pkt[0]}, pkt_exp(0));

      // Random ready and random fill, BURST_LEN=7.
      next_word = 32'h1000;
      fill_left = 1000;
      rnd = 1'b1;
      n = 0;
      while ((fill_left > 0 || sb[1].size() != 0) && n < 20000) begin
         tick();
         n++;
      end
      rnd = 1'b0;
      chk("rand_left", 32'(sb[1].size()), 32'd0);
      chk("rand_beats", 32'(nb[1]), 32'd1000);
      chk("rand_pkt_model", {16'd0, pkt[1]}, pkt_exp(1));
      chk("rand_pkt", {16'd0, pkt[1]}, 32'd142);

      // BURST_LEN=1 with a 4-bit packet counter wrapping.
      tready[2] = 1'b1;
      for (int i = 0; i < 20; i++) load(2, 32'(500 + i));
      drain(2, 100);
      chk("bl1_pkt", {16'd0, pkt[2]}, 32'd4);
      chk("bl1_pkt_model", {16'd0, pkt[2]}, pkt_exp(2));
      chk("bl1_bidx", {16'd0, bidx[2]}, 32'd0);

      // Asynchronous reset with the buffer full.
      tready[0] = 1'b0;
      for (int i = 0; i < 3; i++) load(0, 32'(300 + i));
      repeat (3) tick();
      chk("pre_rst_occ", {30'd0, occ[0]}, 32'd2);
      chk("pre_rst_tvalid", {31'd0, tvalid[0]}, 32'd1);
      #2;
      rst_ = 1'b0;
      #1;
      chk("arst_tvalid", {31'd0, tvalid[0]}, 32'd0);
      chk("arst_occ", {30'd0, occ[0]}, 32'd0);
      chk("arst_bidx", {16'd0, bidx[0]}, 32'd0);
      chk("arst_pkt", {16'd0, pkt[0]}, 32'd0);
      chk("arst_rd_en", {31'd0, rd_en[0]}, 32'd0);
      chk("arst_tdata", tdata[0], 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("arst_hold_rd_en", {31'd0, rd_en[0]}, 32'd0);
      chk("arst_hold_tvalid", {31'd0, tvalid[0]}, 32'd0);
      rst_ = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_axis_drain.md
Name: fifo_axis_drain

Overview:
Read-side consumer for the axi_rab clock-crossing FIFO, in the destination clock domain. It pops first-word-fall-through FIFO data and presents it as an AXI-Stream master with registered outputs and full throughput (2-entry skid buffer). It frames the stream into fixed-length bursts by generating tlast, and keeps beat and packet counters for debug.

Parameters:
DW, 32, data width; matches the FIFO DW.
BURST_LEN, 16, beats per packet; tlast on the last beat; legal range 1..65536.
CNT_W, 16, width of the pkt_cnt debug counter.

Ports:
clk  input  1  destination-domain clock
rst_  input  1  asynchronous active-low reset
en  input  1  drain enable; when low, no new FIFO pops
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DW  FIFO head word, valid whenever fifo_empty is low
fifo_rd_en  output  1  FIFO pop strobe
m_tvalid  output  1  stream valid
m_tready  input  1  stream ready
m_tdata  output  DW  stream data
m_tlast  output  1  last beat of a BURST_LEN packet
occupancy  output  2  entries held (0..2)
beat_idx  output  max(1,$clog2(BURST_LEN))  position of the next captured beat within its packet
pkt_cnt  output  CNT_W  completed packets (tlast handshakes), wraps

Behaviour:
- Clock and reset: one clock, clk. Reset rst_ is asynchronous, active-low.
- Reset values: fifo_rd_en=0, m_tvalid=0, m_tdata=0, m_tlast=0, occupancy=0, beat_idx=0, pkt_cnt=0, state=EMPTY.
- State machine states: EMPTY, ONE, TWO. Storage is two registers:
  - head: drives m_tdata and m_tlast.
  - skid: second entry, used only in TWO.
- Pop rule (combinational): fifo_rd_en = en & ~fifo_empty & (state!=TWO). The pop strobe never asserts while the FIFO is empty.
- push = fifo_rd_en: {fifo_data, tlast_calc} is captured at the clk edge where fifo_rd_en is high.
- out = m_tvalid & m_tready.
- Transitions:
  - EMPTY: push goes to ONE and loads head.
  - ONE, push without out: goes to TWO and loads skid.
  - ONE, out without push: goes to EMPTY.
  - ONE, push and out: stays in ONE and loads head with the new word.
  - TWO, out: goes to ONE, skid moves to head. push cannot occur in TWO.
- Outputs:
  - m_tvalid = state!=EMPTY, driven from registered state.
  - m_tdata and m_tlast hold stable while m_tvalid & ~m_tready.
  - occupancy = 0/1/2 per state.
- Latency and throughput: a word popped at edge N appears on m_tdata after edge N, i.e. one cycle of latency. With m_tready held high, one beat per cycle is sustained indefinitely.
- Framing:
  - tlast_calc = (beat_idx == BURST_LEN-1).
  - On push, beat_idx increments, wrapping to 0 after BURST_LEN-1.
  - tlast is attached at capture time and travels with its word.
  - BURST_LEN=1 gives tlast on every beat, with beat_idx held at 0.
- pkt_cnt increments on out & m_tlast and wraps modulo 2^CNT_W.
- en low mid-packet: pops stop; held entries still drain on m_tready; beat_idx is preserved. Framing resumes from the same beat when en returns high.
- m_tready low: the buffer fills to TWO, then fifo_rd_en deasserts. No beat is lost or duplicated.
- fifo_empty rising while in ONE or TWO: the buffer drains normally.
- Reset mid-operation: all entries are discarded and outputs return to reset values asynchronously. Any word popped in the reset cycle is lost; this is accepted because the FIFO is reset alongside.
- No combinational path from m_tready to m_tvalid or m_tdata. fifo_rd_en depends only on en, fifo_empty and registered state.

Decomposition:
- Shared header axi_rab_stream_defs.vh holds the state encodings (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and a clog2-min-1 width macro.
- One natural sub-module: rab_skid_buf. It contains the 2-entry head/skid buffer and its state machine, parameterised on entry width (DW+1).
- The top level adds the pop logic, beat_idx and pkt_cnt.

Test Plan:
- Back-to-back drain: preload 32 words 0..31, m_tready=1, en=1, BURST_LEN=16. Expect 32 consecutive beats, data 0..31, tlast on beats 15 and 31, pkt_cnt=2, one cycle from first pop to first m_tvalid.
- Backpressure: m_tready=0 with 5 words queued. Expect occupancy reaching 2, fifo_rd_en low, m_tdata=0 held. Then release m_tready: expect 0,1,2,3,4 with no gaps or duplicates.
- Random m_tready (50%) with random FIFO fill over 1000 words, BURST_LEN=7. Expect the data sequence preserved, tlast exactly on every 7th beat, and pkt_cnt=142 at the end.
- en drop mid-packet: drop en after beat 5 of 16 for 10 cycles. Expect buffered beats to drain, no pops while en=0, and on resume the next beat has beat_idx=6, with tlast landing on global beat 15.
- BURST_LEN=1 with pkt_cnt wrap (CNT_W=4): 20 beats gives tlast on every beat and pkt_cnt=4.
- Async reset asserted while occupancy=2 and m_tvalid=1: expect m_tvalid=0, occupancy=0, beat_idx=0 and pkt_cnt=0 immediately (before the next clk edge), and fifo_rd_en=0 for as long as rst_ is low.
